// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the multi-cycle core sequencer.
//   state_t         - sequencer FSM states
//   OPC_*           - RV32I major opcodes (instr[6:0])
//   CL_*            - bit positions of the one-hot instruction class vector
//   WB_SEL_*        - register-bank write-back source encodings
//   class_opcode()  - maps a class index to its opcode
package cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_RETIRE,
    S_HALTED,
    S_FAULT
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam int NUM_CLASSES = 9;
  localparam int CL_OP     = 0;
  localparam int CL_OP_IMM = 1;
  localparam int CL_LUI    = 2;
  localparam int CL_AUIPC  = 3;
  localparam int CL_LOAD   = 4;
  localparam int CL_STORE  = 5;
  localparam int CL_BRANCH = 6;
  localparam int CL_JAL    = 7;
  localparam int CL_JALR   = 8;

  typedef logic [NUM_CLASSES-1:0] class_t;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;

  function automatic logic [6:0] class_opcode(input int cls);
    case (cls)
      CL_OP:     return OPC_OP;
      CL_OP_IMM: return OPC_OP_IMM;
      CL_LUI:    return OPC_LUI;
      CL_AUIPC:  return OPC_AUIPC;
      CL_LOAD:   return OPC_LOAD;
      CL_STORE:  return OPC_STORE;
      CL_BRANCH: return OPC_BRANCH;
      CL_JAL:    return OPC_JAL;
      CL_JALR:   return OPC_JALR;
      default:   return 7'b0000000;
    endcase
  endfunction

endpackage

// File: rtl/cpu_sequencer_classifier.sv
// opcode_classifier: purely combinational opcode decode.
//   opcode in  7          instr[6:0]
//   cls    out class_t    one-hot instruction class (all zero if unknown)
//   legal  out 1          opcode belongs to a supported class
module opcode_classifier
  import cpu_pkg::*;
(
  input  logic [6:0] opcode,
  output class_t     cls,
  output logic       legal
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLASSES; gi++) begin : g_match
      assign cls[gi] = (opcode == class_opcode(gi));
    end
  endgenerate

  assign legal = |cls;

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control FSM for the single-issue RV32I core.
//   clock, reset(active-low, async)      clocking / reset
//   halt, opcode, branch_taken           core status inputs
//   mem_ready                            memory handshake acknowledge
//   mem_req, mem_we, addr_sel            memory request and address mux
//   ir_load, decoder_en, alu_en          datapath stage enables
//   reg_we, wb_sel                       register-bank write strobe / source
//   pc_inc, pc_load                      PC update (pc_load wins)
//   halted, fault                        core status (fault is sticky)
//   instret                              retired-instruction counter
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             halt,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_load,
  output logic             decoder_en,
  output logic             alu_en,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instret
);

  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t           state_reg, state_next;
  logic [TO_W-1:0]  to_cnt_reg, to_cnt_next;
  logic [CNT_W-1:0] instret_reg;
  class_t           cls_reg;
  class_t           cls_now;
  logic             legal_now;

  logic       mem_req_raw, mem_we_raw, addr_sel_raw, ir_load_raw;
  logic       decoder_en_raw, alu_en_raw, reg_we_raw, pc_inc_raw, pc_load_raw;
  logic [1:0] wb_sel_raw;
  logic       is_jump, is_reg_class;

  opcode_classifier u_classifier (
    .opcode (opcode),
    .cls    (cls_now),
    .legal  (legal_now)
  );

  assign is_jump      = cls_reg[CL_JAL] | cls_reg[CL_JALR];
  assign is_reg_class = cls_reg[CL_OP] | cls_reg[CL_OP_IMM] | cls_reg[CL_LUI] |
                        cls_reg[CL_AUIPC] | is_jump;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= S_FETCH;
      to_cnt_reg  <= '0;
      instret_reg <= '0;
      cls_reg     <= '0;
    end else begin
      state_reg  <= state_next;
      to_cnt_reg <= to_cnt_next;
      // Class is latched once so later stages do not depend on opcode staying stable.
      if (state_reg == S_DECODE) cls_reg <= cls_now;
      if (state_reg == S_RETIRE) instret_reg <= instret_reg + 1'b1;
    end
  end

  always_comb begin
    state_next     = state_reg;
    to_cnt_next    = '0;
    mem_req_raw    = 1'b0;
    mem_we_raw     = 1'b0;
    addr_sel_raw   = 1'b0;
    ir_load_raw    = 1'b0;
    decoder_en_raw = 1'b0;
    alu_en_raw     = 1'b0;
    reg_we_raw     = 1'b0;
    wb_sel_raw     = WB_SEL_ALU;
    pc_inc_raw     = 1'b0;
    pc_load_raw    = 1'b0;
    case (state_reg)
      S_FETCH: begin
        // A zero wait count means no request has been issued yet, so halt
        // can still be honoured without breaking an open handshake.
        if (halt && to_cnt_reg == '0) begin
          state_next = S_HALTED;
        end else begin
          mem_req_raw = 1'b1;
          if (mem_ready) begin
            ir_load_raw = 1'b1;
            state_next  = S_DECODE;
          end else if (to_cnt_reg == TO_LAST) begin
            state_next = S_FAULT;
          end else begin
            to_cnt_next = to_cnt_reg + 1'b1;
          end
        end
      end
      S_DECODE: begin
        decoder_en_raw = 1'b1;
        state_next     = legal_now ? S_EXECUTE : S_FAULT;
      end
      S_EXECUTE: begin
        alu_en_raw = 1'b1;
        if (cls_reg[CL_LOAD] || cls_reg[CL_STORE]) begin
          state_next = S_MEM;
        end else if (cls_reg[CL_BRANCH]) begin
          pc_load_raw = branch_taken;
          pc_inc_raw  = !branch_taken;
          state_next  = S_RETIRE;
        end else if (is_reg_class) begin
          state_next = S_WRITEBACK;
        end else begin
          state_next = S_FAULT;
        end
      end
      S_MEM: begin
        mem_req_raw  = 1'b1;
        addr_sel_raw = 1'b1;
        mem_we_raw   = cls_reg[CL_STORE];
        if (mem_ready) begin
          state_next = cls_reg[CL_STORE] ? S_RETIRE : S_WRITEBACK;
        end else if (to_cnt_reg == TO_LAST) begin
          state_next = S_FAULT;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end
      S_WRITEBACK: begin
        reg_we_raw = 1'b1;
        if (cls_reg[CL_LOAD])   wb_sel_raw = WB_SEL_LOAD;
        else if (is_jump)       wb_sel_raw = WB_SEL_PC4;
        pc_load_raw = is_jump;
        pc_inc_raw  = !is_jump;
        state_next  = S_RETIRE;
      end
      S_RETIRE: begin
        // Stores never pass through WRITEBACK, so their PC step lands here.
        pc_inc_raw = cls_reg[CL_STORE];
        state_next = S_FETCH;
      end
      S_HALTED: begin
        if (!halt) state_next = S_FETCH;
      end
      S_FAULT: begin
        state_next = S_FAULT;
      end
      default: begin
        state_next = S_FAULT;
      end
    endcase
  end

  // Strobes are gated by reset so an asserted reset drops them without waiting for a clock.
  assign mem_req    = mem_req_raw & reset;
  assign mem_we     = mem_we_raw & reset;
  assign addr_sel   = addr_sel_raw & reset;
  assign ir_load    = ir_load_raw & reset;
  assign decoder_en = decoder_en_raw & reset;
  assign alu_en     = alu_en_raw & reset;
  assign reg_we     = reg_we_raw & reset;
  assign wb_sel     = reset ? wb_sel_raw : WB_SEL_ALU;
  assign pc_inc     = pc_inc_raw & reset;
  assign pc_load    = pc_load_raw & reset;
  assign halted     = (state_reg == S_HALTED);
  assign fault      = (state_reg == S_FAULT);
  assign instret    = instret_reg;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed bench for cpu_sequencer. Each cycle the expected
// strobe vector and instret value are queued as the inputs are driven, then
// popped and compared against the DUT on the falling edge.
module tb_cpu_sequencer;

  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 8;

  // Strobe vector bit layout: {mem_req, mem_we, addr_sel, ir_load, decoder_en,
  // alu_en, reg_we, wb_sel[1:0], pc_inc, pc_load, halted, fault}
  localparam logic [12:0] B_NONE = 13'h0000;
  localparam logic [12:0] B_MREQ = 13'h1000;
  localparam logic [12:0] B_MWE  = 13'h0800;
  localparam logic [12:0] B_ASEL = 13'h0400;
  localparam logic [12:0] B_IRL  = 13'h0200;
  localparam logic [12:0] B_DEC  = 13'h0100;
  localparam logic [12:0] B_ALU  = 13'h0080;
  localparam logic [12:0] B_RWE  = 13'h0040;
  localparam logic [12:0] B_WB2  = 13'h0020;
  localparam logic [12:0] B_WB1  = 13'h0010;
  localparam logic [12:0] B_PCI  = 13'h0008;
  localparam logic [12:0] B_PCL  = 13'h0004;
  localparam logic [12:0] B_HLT  = 13'h0002;
  localparam logic [12:0] B_FLT  = 13'h0001;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             halt = 1'b0;
  logic [6:0]       opcode = 7'b0;
  logic             branch_taken = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req, mem_we, addr_sel, ir_load, decoder_en, alu_en;
  logic             reg_we, pc_inc, pc_load, halted, fault;
  logic [1:0]       wb_sel;
  logic [CNT_W-1:0] instret;
  logic [12:0]      obs;

  typedef struct {
    logic [12:0]      vec;
    logic [CNT_W-1:0] cnt;
    string            tag;
  } exp_t;

  exp_t             sb_q[$];
  logic [CNT_W-1:0] model_instret = '0;
  int               n_cmp = 0;
  int               n_bad = 0;

  always #5 clock = ~clock;

  cpu_sequencer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .halt         (halt),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .addr_sel     (addr_sel),
    .ir_load      (ir_load),
    .decoder_en   (decoder_en),
    .alu_en       (alu_en),
    .reg_we       (reg_we),
    .wb_sel       (wb_sel),
    .pc_inc       (pc_inc),
    .pc_load      (pc_load),
    .halted       (halted),
    .fault        (fault),
    .instret      (instret)
  );

  assign obs = {mem_req, mem_we, addr_sel, ir_load, decoder_en, alu_en,
                reg_we, wb_sel, pc_inc, pc_load, halted, fault};

  task automatic push_exp(input logic [12:0] vec, input string tag);
    exp_t e;
    e.vec = vec;
    e.cnt = model_instret;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_empty: observed %h expected <queued entry>", obs);
    end else begin
      e = sb_q.pop_front();
      n_cmp++;
      assert (obs === e.vec) else begin
        n_bad++;
        $error("FAIL %s strobes: observed %h expected %h", e.tag, obs, e.vec);
      end
      n_cmp++;
      assert (instret === e.cnt) else begin
        n_bad++;
        $error("FAIL %s instret: observed %0d expected %0d", e.tag, instret, e.cnt);
      end
    end
  endtask

  // One clock cycle, entered and left at posedge+1.
  task automatic cyc(input logic rdy, input logic hlt, input logic tkn,
                     input logic [12:0] vec, input string tag);
    mem_ready    = rdy;
    halt         = hlt;
    branch_taken = tkn;
    push_exp(vec, tag);
    @(negedge clock);
    check_now();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    halt         = 1'b0;
    mem_ready    = 1'b0;
    branch_taken = 1'b0;
    model_instret = '0;
    push_exp(B_NONE, "reset");
    #1;
    check_now();
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic fetch(input int waits, input logic [6:0] opc);
    opcode = opc;
    for (int i = 0; i < waits; i++) cyc(1'b0, 1'b0, 1'b0, B_MREQ, "fetch_wait");
    cyc(1'b1, 1'b0, 1'b0, B_MREQ | B_IRL, "fetch");
  endtask

  task automatic run_reg(input logic [6:0] opc, input logic jump, input int waits);
    fetch(waits, opc);
    cyc(1'b0, 1'b0, 1'b1, B_DEC, "decode");
    cyc(1'b0, 1'b0, 1'b0, B_ALU, "execute");
    cyc(1'b0, 1'b0, 1'b0, jump ? (B_RWE | B_WB2 | B_PCL) : (B_RWE | B_PCI), "writeback");
    cyc(1'b0, 1'b0, 1'b0, B_NONE, "retire");
    model_instret++;
  endtask

  task automatic run_load(input int waits);
    fetch(0, 7'b0000011);
    cyc(1'b0, 1'b0, 1'b0, B_DEC, "ld_decode");
    cyc(1'b0, 1'b0, 1'b0, B_ALU, "ld_execute");
    for (int i = 0; i < waits; i++) cyc(1'b0, 1'b0, 1'b0, B_MREQ | B_ASEL, "ld_mem_wait");
    cyc(1'b1, 1'b0, 1'b0, B_MREQ | B_ASEL, "ld_mem");
    cyc(1'b0, 1'b0, 1'b0, B_RWE | B_WB1 | B_PCI, "ld_writeback");
    cyc(1'b0, 1'b0, 1'b0, B_NONE, "ld_retire");
    model_instret++;
  endtask

  task automatic run_store(input int waits, input logic hlt);
    fetch(0, 7'b0100011);
    cyc(1'b0, hlt, 1'b0, B_DEC, "st_decode");
    cyc(1'b0, hlt, 1'b0, B_ALU, "st_execute");
    for (int i = 0; i < waits; i++) cyc(1'b0, hlt, 1'b0, B_MREQ | B_ASEL | B_MWE, "st_mem_wait");
    cyc(1'b1, hlt, 1'b0, B_MREQ | B_ASEL | B_MWE, "st_mem");
    cyc(1'b0, hlt, 1'b0, B_PCI, "st_retire");
    model_instret++;
  endtask

  task automatic run_branch(input logic tkn);
    fetch(0, 7'b1100011);
    cyc(1'b0, 1'b0, 1'b0, B_DEC, "br_decode");
    cyc(1'b0, 1'b0, tkn, B_ALU | (tkn ? B_PCL : B_PCI), "br_execute");
    cyc(1'b0, 1'b0, tkn, B_NONE, "br_retire");
    model_instret++;
  endtask

  initial begin
    @(posedge clock);
    #1;
    do_reset();

    // Register-writing classes
    run_reg(7'b0010011, 1'b0, 0);   // ADDI
    run_reg(7'b0110011, 1'b0, 0);   // OP
    run_reg(7'b0110111, 1'b0, 1);   // LUI
    run_reg(7'b0010111, 1'b0, 0);   // AUIPC
    run_reg(7'b1101111, 1'b1, 0);   // JAL
    run_reg(7'b1100111, 1'b1, 2);   // JALR

    // Memory and branch classes
    run_load(0);
    run_load(3);
    run_store(0, 1'b0);
    run_store(2, 1'b0);
    run_branch(1'b1);
    run_branch(1'b0);

    // Fetch ready arrives on the last permitted waiting cycle
    run_reg(7'b0010011, 1'b0, MEM_TIMEOUT - 1);

    // Halt raised during a store: store completes, then the core stops
    run_store(1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, B_NONE, "halt_fetch");
    cyc(1'b0, 1'b1, 1'b0, B_HLT, "halted");
    cyc(1'b1, 1'b1, 1'b0, B_HLT, "halted");
    cyc(1'b0, 1'b0, 1'b0, B_HLT, "halt_release");
    run_reg(7'b0010011, 1'b0, 0);

    // Illegal opcode traps and stays trapped until reset
    fetch(0, 7'b1111111);
    cyc(1'b0, 1'b0, 1'b0, B_DEC, "ill_decode");
    for (int i = 0; i < 4; i++) cyc(1'b1, i[0], 1'b1, B_FLT, "ill_fault");
    do_reset();
    run_reg(7'b0010011, 1'b0, 0);

    // Fetch timeout
    opcode = 7'b0010011;
    for (int i = 0; i < MEM_TIMEOUT; i++) cyc(1'b0, 1'b0, 1'b0, B_MREQ, "to_fetch_wait");
    cyc(1'b1, 1'b0, 1'b0, B_FLT, "to_fetch_fault");
    cyc(1'b0, 1'b0, 1'b0, B_FLT, "to_fetch_fault");
    do_reset();

    // Memory-stage timeout on a load
    fetch(0, 7'b0000011);
    cyc(1'b0, 1'b0, 1'b0, B_DEC, "to_ld_decode");
    cyc(1'b0, 1'b0, 1'b0, B_ALU, "to_ld_execute");
    for (int i = 0; i < MEM_TIMEOUT; i++) cyc(1'b0, 1'b0, 1'b0, B_MREQ | B_ASEL, "to_mem_wait");
    cyc(1'b1, 1'b0, 1'b0, B_FLT, "to_mem_fault");
    do_reset();

    // Asynchronous reset in the middle of a memory transfer
    run_reg(7'b0010011, 1'b0, 0);
    fetch(0, 7'b0000011);
    cyc(1'b0, 1'b0, 1'b0, B_DEC, "ar_decode");
    cyc(1'b0, 1'b0, 1'b0, B_ALU, "ar_execute");
    cyc(1'b0, 1'b0, 1'b0, B_MREQ | B_ASEL, "ar_mem_wait");
    do_reset();
    run_reg(7'b0010011, 1'b0, 0);

    // instret wraps modulo 2^CNT_W
    for (int i = 0; i < 260; i++) run_reg(7'b0010011, 1'b0, 0);
    cyc(1'b0, 1'b0, 1'b0, B_MREQ, "wrap_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
